// File: rtl/cache_if_pkg.sv
// Shared types and constants for the cache refill/write-back responder.
package cache_if_pkg;

  localparam logic [2:0]  TYPE_WORD = 3'b010;
  localparam logic [2:0]  TYPE_LINE = 3'b100;
  localparam int unsigned LAT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_WAIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       is_line;
    logic [1:0] word;
  } rd_payload_t;

  typedef struct packed {
    logic         is_line;
    logic [1:0]   word;
    logic [3:0]   strb;
    logic [127:0] data;
  } wr_payload_t;

endpackage

// File: rtl/cache_mem_bank.sv
// One word-in-line bank: single-port RAM, byte write enables, registered read.
module cache_mem_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/cache_axi_responder.sv
// Memory-side responder for the D-cache rd/ret/wr ports, backed by four word banks.
module cache_axi_responder
  import cache_if_pkg::*;
#(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  localparam int unsigned LINE_AW = MEM_AW - 2;

  state_e             r_state, w_state_nxt;
  logic [LAT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_beat, w_beat_nxt;
  logic               r_ret_valid, w_ret_valid_nxt;
  logic               r_ret_last, w_ret_last_nxt;
  logic [31:0]        r_ret_data, w_ret_data_nxt;
  rd_payload_t        r_rd;
  wr_payload_t        r_wr;
  logic [LINE_AW-1:0] r_rd_line, r_wr_line, w_bank_addr;
  logic [3:0][31:0]   w_bank_q;
  logic               w_rd_rdy, w_wr_rdy, w_rd_acc, w_wr_acc, w_commit;
  logic               w_unused;

  assign rd_rdy    = w_rd_rdy && !reset;
  assign wr_rdy    = w_wr_rdy && !reset;
  assign w_rd_acc  = rd_req && rd_rdy;
  assign w_wr_acc  = wr_req && wr_rdy;
  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_ret_data;
  assign w_unused  = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

  // Banks read the incoming line while idle so a 1-cycle latency still has data ready.
  always_comb begin
    w_bank_addr = r_rd_line;
    if (r_state == ST_IDLE)         w_bank_addr = rd_addr[MEM_AW+1:4];
    else if (r_state == ST_WR_WAIT) w_bank_addr = r_wr_line;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_beat_nxt      = r_beat;
    w_ret_valid_nxt = 1'b0;
    w_ret_last_nxt  = 1'b0;
    w_ret_data_nxt  = '0;
    w_rd_rdy        = 1'b0;
    w_wr_rdy        = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wr_rdy  = 1'b1;
        w_rd_rdy  = !wr_req;
        w_cnt_nxt = '0;
        if (wr_req)      w_state_nxt = ST_WR_WAIT;
        else if (rd_req) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_cnt == LAT_W'(RD_LAT - 1)) begin
          w_state_nxt     = ST_RD_BURST;
          w_beat_nxt      = r_rd.is_line ? 2'd0 : r_rd.word;
          w_ret_valid_nxt = 1'b1;
          w_ret_last_nxt  = !r_rd.is_line;
          w_ret_data_nxt  = w_bank_q[w_beat_nxt];
        end else begin
          w_cnt_nxt = LAT_W'(r_cnt + 1'b1);
        end
      end
      ST_RD_BURST: begin
        if (r_ret_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_beat_nxt      = 2'(r_beat + 1'b1);
          w_ret_valid_nxt = 1'b1;
          w_ret_last_nxt  = (w_beat_nxt == 2'd3);
          w_ret_data_nxt  = w_bank_q[w_beat_nxt];
        end
      end
      ST_WR_WAIT: begin
        if (r_cnt == LAT_W'(WR_LAT)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = LAT_W'(r_cnt + 1'b1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
      r_ret_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_beat      <= w_beat_nxt;
      r_ret_valid <= w_ret_valid_nxt;
      r_ret_last  <= w_ret_last_nxt;
      r_ret_data  <= w_ret_data_nxt;
    end
  end

  // Request payload capture; only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_rd_line    <= rd_addr[MEM_AW+1:4];
      r_rd.is_line <= (rd_type == TYPE_LINE);
      r_rd.word    <= rd_addr[3:2];
    end
    if (w_wr_acc) begin
      r_wr_line    <= wr_addr[MEM_AW+1:4];
      r_wr.is_line <= (wr_type == TYPE_LINE);
      r_wr.word    <= wr_addr[3:2];
      r_wr.strb    <= wr_wstrb;
      r_wr.data    <= wr_data;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [3:0]  w_we;
    logic [31:0] w_wdata;

    assign w_we    = !w_commit ? 4'h0 :
                     r_wr.is_line ? 4'hF :
                     (r_wr.word == 2'(b)) ? r_wr.strb : 4'h0;
    assign w_wdata = r_wr.is_line ? r_wr.data[32*b +: 32] : r_wr.data[31:0];

    cache_mem_bank #(.AW(LINE_AW)) u_bank (
      .clk     (clk),
      .i_addr  (w_bank_addr),
      .i_we    (w_we),
      .i_wdata (w_wdata),
      .o_rdata (w_bank_q[b])
    );
  end

endmodule

// File: tb/tb_cache_axi_responder.sv
// Self-checking bench: three responders with different latencies against a word-array memory model.
module tb_cache_axi_responder;

  localparam int unsigned NDUT   = 3;
  localparam int unsigned MEM_AW = 12;
  localparam int unsigned WORDS  = 1 << MEM_AW;
  localparam logic [2:0]  T_LINE = 3'b100;
  localparam logic [2:0]  T_WORD = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         rd_req    [NDUT];
  logic [2:0]   rd_type   [NDUT];
  logic [31:0]  rd_addr   [NDUT];
  logic         rd_rdy    [NDUT];
  logic         ret_valid [NDUT];
  logic         ret_last  [NDUT];
  logic [31:0]  ret_data  [NDUT];
  logic         wr_req    [NDUT];
  logic [2:0]   wr_type   [NDUT];
  logic [31:0]  wr_addr   [NDUT];
  logic [3:0]   wr_wstrb  [NDUT];
  logic [127:0] wr_data   [NDUT];
  logic         wr_rdy    [NDUT];

  logic [31:0] model [NDUT][WORDS];
  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cache_axi_responder #(
      .MEM_AW (MEM_AW),
      .RD_LAT (g == 0 ? 2 : (g == 1 ? 1 : 7)),
      .WR_LAT (g == 0 ? 1 : 4)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req[g]),
      .rd_type   (rd_type[g]),
      .rd_addr   (rd_addr[g]),
      .rd_rdy    (rd_rdy[g]),
      .ret_valid (ret_valid[g]),
      .ret_last  (ret_last[g]),
      .ret_data  (ret_data[g]),
      .wr_req    (wr_req[g]),
      .wr_type   (wr_type[g]),
      .wr_addr   (wr_addr[g]),
      .wr_wstrb  (wr_wstrb[g]),
      .wr_data   (wr_data[g]),
      .wr_rdy    (wr_rdy[g])
    );
  end

  function automatic int rd_lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 7);
  endfunction

  function automatic int wr_lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[MEM_AW+1:2]);
  endfunction

  task automatic model_write(input int d, input logic [2:0] ty, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [127:0] data);
    int base;
    base = widx(addr);
    if (ty == T_LINE) begin
      for (int w = 0; w < 4; w++) model[d][(base & ~3) + w] = data[32*w +: 32];
    end else begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[d][base][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      rd_req[d] = 1'b0; rd_type[d] = T_WORD; rd_addr[d] = '0;
      wr_req[d] = 1'b0; wr_type[d] = T_WORD; wr_addr[d] = '0;
      wr_wstrb[d] = '0; wr_data[d] = '0;
    end
  endtask

  task automatic write_op(input int d, input logic [2:0] ty, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [127:0] data);
    int n;
    @(negedge clk);
    n_checks++;
    if (wr_rdy[d] !== 1'b1) begin
      n_fail++; $display("FAIL wr_rdy_idle dut%0d: got %b want 1", d, wr_rdy[d]);
    end
    wr_req[d] = 1'b1; wr_type[d] = ty; wr_addr[d] = addr; wr_wstrb[d] = strb; wr_data[d] = data;
    @(negedge clk);
    wr_req[d] = 1'b0;
    n = 1;
    while (wr_rdy[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != wr_lat(d) + 2) begin
      n_fail++; $display("FAIL wr_latency dut%0d: got %0d cycles want %0d", d, n, wr_lat(d) + 2);
    end
    model_write(d, ty, addr, strb, data);
  endtask

  // Expects the read to have been accepted at the posedge just before the current negedge.
  task automatic collect_read(input int d, input logic [2:0] ty, input logic [31:0] addr);
    logic [31:0] exp_q[$];
    logic [34:0] got, want;
    int n;
    if (ty == T_LINE) for (int w = 0; w < 4; w++) exp_q.push_back(model[d][(widx(addr) & ~3) + w]);
    else              exp_q.push_back(model[d][widx(addr)]);
    n = 1;
    while (ret_valid[d] !== 1'b1 && n < 40) begin
      n_checks++;
      if (rd_rdy[d] !== 1'b0) begin
        n_fail++; $display("FAIL rd_rdy_wait dut%0d: got %b want 0", d, rd_rdy[d]);
      end
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != rd_lat(d) + 1) begin
      n_fail++; $display("FAIL rd_latency dut%0d: got %0d cycles want %0d", d, n, rd_lat(d) + 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      got  = {ret_valid[d], ret_last[d], rd_rdy[d], ret_data[d]};
      want = {1'b1, (i == exp_q.size() - 1), 1'b0, exp_q[i]};
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL beat%0d dut%0d addr %h: got v/l/rdy/data %h want %h", i, d, addr, got, want);
      end
    end
    @(negedge clk);
    got  = {ret_valid[d], ret_last[d], rd_rdy[d], ret_data[d]};
    want = {1'b0, 1'b0, 1'b1, 32'h0};
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL post_burst dut%0d: got v/l/rdy/data %h want %h", d, got, want);
    end
  endtask

  task automatic read_op(input int d, input logic [2:0] ty, input logic [31:0] addr);
    @(negedge clk);
    n_checks++;
    if (rd_rdy[d] !== 1'b1) begin
      n_fail++; $display("FAIL rd_rdy_idle dut%0d: got %b want 1", d, rd_rdy[d]);
    end
    rd_req[d] = 1'b1; rd_type[d] = ty; rd_addr[d] = addr;
    @(negedge clk);
    rd_req[d] = 1'b0;
    collect_read(d, ty, addr);
  endtask

  task automatic test_reset();
    logic [35:0] got;
    reset = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      got = {rd_rdy[d], wr_rdy[d], ret_valid[d], ret_last[d], ret_data[d]};
      n_checks++;
      if (got !== 36'h0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: got %h want 0", d, got);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if ({rd_rdy[d], wr_rdy[d], ret_valid[d]} !== 3'b110) begin
        n_fail++; $display("FAIL post_reset_ready dut%0d: got %b want 110", d, {rd_rdy[d], wr_rdy[d], ret_valid[d]});
      end
    end
  endtask

  task automatic test_directed();
    write_op(0, T_LINE, 32'h0000_1230, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
    n_checks++;
    if (model[0][widx(32'h0000_1234)] !== 32'h22) begin
      n_fail++; $display("FAIL model_line dut0: got %h want 00000022", model[0][widx(32'h0000_1234)]);
    end
    read_op(0, T_LINE, 32'h0000_1238);
    write_op(0, T_WORD, 32'h0000_1234, 4'b0010, {96'h0, 32'hAABB_CCDD});
    n_checks++;
    if (model[0][widx(32'h0000_1234)] !== 32'h0000_CC22) begin
      n_fail++; $display("FAIL model_word dut0: got %h want 0000cc22", model[0][widx(32'h0000_1234)]);
    end
    read_op(0, T_WORD, 32'h0000_1234);
    read_op(0, T_LINE, 32'h0000_1230 | 32'h0010_4000);
  endtask

  task automatic test_simultaneous();
    logic [127:0] data;
    int n;
    data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_req[0] = 1'b1; wr_type[0] = T_LINE; wr_addr[0] = 32'h0000_1230; wr_data[0] = data;
    rd_req[0] = 1'b1; rd_type[0] = T_LINE; rd_addr[0] = 32'h0000_1230;
    #1;
    n_checks++;
    if ({wr_rdy[0], rd_rdy[0]} !== 2'b10) begin
      n_fail++; $display("FAIL collision_ready: got wr/rd %b want 10", {wr_rdy[0], rd_rdy[0]});
    end
    @(negedge clk);
    wr_req[0] = 1'b0;
    model_write(0, T_LINE, 32'h0000_1230, 4'h0, data);
    n = 1;
    while (rd_rdy[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != wr_lat(0) + 2) begin
      n_fail++; $display("FAIL collision_rd_delay: got %0d cycles want %0d", n, wr_lat(0) + 2);
    end
    @(negedge clk);
    rd_req[0] = 1'b0;
    collect_read(0, T_LINE, 32'h0000_1230);
  endtask

  task automatic test_reset_mid();
    logic [127:0] data;
    int n;
    @(negedge clk);
    rd_req[0] = 1'b1; rd_type[0] = T_LINE; rd_addr[0] = 32'h0000_1230;
    @(negedge clk);
    rd_req[0] = 1'b0;
    n = 0;
    while (ret_valid[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_checks++;
    if ({ret_valid[0], ret_data[0]} !== {1'b1, model[0][widx(32'h0000_1234)]}) begin
      n_fail++; $display("FAIL reset_mid_beat2: got %h want %h", {ret_valid[0], ret_data[0]}, {1'b1, model[0][widx(32'h0000_1234)]});
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ret_valid[0], ret_last[0], ret_data[0]} !== 34'h0) begin
      n_fail++; $display("FAIL reset_mid_ret: got %h want 0", {ret_valid[0], ret_last[0], ret_data[0]});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_rdy[0], wr_rdy[0], ret_valid[0]} !== 3'b110) begin
      n_fail++; $display("FAIL reset_mid_idle: got %b want 110", {rd_rdy[0], wr_rdy[0], ret_valid[0]});
    end
    read_op(0, T_LINE, 32'h0000_1230);
    // A write aborted by reset in its wait window must leave memory untouched.
    write_op(1, T_LINE, 32'h0000_1230, 4'h0, {$urandom, $urandom, $urandom, $urandom});
    data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_req[1] = 1'b1; wr_type[1] = T_LINE; wr_addr[1] = 32'h0000_1230; wr_data[1] = data;
    @(negedge clk);
    wr_req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_op(1, T_LINE, 32'h0000_1230);
  endtask

  task automatic test_random();
    logic [2:0]  rtypes [5];
    logic [31:0] addr;
    logic [2:0]  ty;
    rtypes = '{3'b100, 3'b010, 3'b000, 3'b111, 3'b001};
    for (int d = 0; d < NDUT; d++) begin
      for (int l = 0; l < 8; l++)
        write_op(d, T_LINE, 32'h0000_3000 + 32'(l * 16), 4'h0, {$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < 24; k++) begin
        addr = 32'h0000_3000 + 32'($urandom_range(0, 127)) + ($urandom & 32'hFFFF_C000);
        if ($urandom_range(0, 1) == 0) begin
          ty = ($urandom_range(0, 1) == 0) ? T_LINE : T_WORD;
          write_op(d, ty, addr, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end else begin
          ty = rtypes[$urandom_range(0, 4)];
          read_op(d, ty, addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_axi_responder.md
# cache_axi_responder

Memory-side responder for the D-cache refill/replace interface: accepts the cache's read requests (`rd_req`) and write-back requests (`wr_req`) and serves them from an internal banked word RAM. Read data returns as a beat stream (`ret_valid`/`ret_last`/`ret_data`) after a programmable latency. It stands in for the AXI bridge plus memory in cache-level simulation and FPGA bring-up, and is the far end of the cache's `rd_*`/`ret_*`/`wr_*` ports.

## Interface
- `MEM_AW`, 12: log2 of RAM depth in 32-bit words; upper address bits ignored (aliasing).
- `RD_LAT`, 2: idle cycles between read accept and first `ret_valid`; legal 1..15.
- `WR_LAT`, 1: cycles between write accept and RAM update; legal 1..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: read request.
- `rd_type` in 3: 3'b100 = 4-word line, 3'b010 = single word; others are treated as 3'b010.
- `rd_addr` in 32: byte address.
- `rd_rdy` out 1: read request accepted this cycle when high with `rd_req`.
- `ret_valid` out 1: return beat valid; no backpressure.
- `ret_last` out 1: final beat of the response.
- `ret_data` out 32: return data.
- `wr_req` in 1: write request.
- `wr_type` in 3: 3'b100 = full line, 3'b010 = single word.
- `wr_addr` in 32: byte address.
- `wr_wstrb` in 4: byte enables, used for word writes only.
- `wr_data` in 128: line data, word n at [32n+31:32n]; word writes use [31:0].
- `wr_rdy` out 1: write request accepted this cycle when high with `wr_req`.

## Operation
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE:
  - `wr_rdy` = 1.
  - `rd_rdy` = !`wr_req`. Write wins a simultaneous request; the read stays pending and is accepted on the next IDLE cycle.
- Read accept (`rd_req && rd_rdy`):
  - Latch line base `rd_addr[MEM_AW+1:4]`, word `rd_addr[3:2]`, and beat count (4 or 1).
  - Go to RD_WAIT.
- RD_WAIT: count `RD_LAT` cycles, then go to RD_BURST.
- RD_BURST:
  - One beat per cycle with `ret_valid` = 1.
  - Line read: words 0,1,2,3 of the line in order (critical-word-first is not supported; `rd_addr[3:0]` is ignored).
  - Word read: one beat from the latched word.
  - `ret_last` = 1 on the final beat; go to IDLE on the next edge.
- Write accept: latch address, data, strobes and type; go to WR_WAIT.
- WR_WAIT:
  - After `WR_LAT` cycles, commit to RAM in one cycle (all 4 banks for a line; one bank, byte-masked, for a word), then go to IDLE.
  - `wr_addr[3:0]` is ignored for line writes.
- `rd_rdy` = `wr_rdy` = 0 in every non-IDLE state. The cache clears its beat counter on `rd_rdy`, so `rd_rdy` must stay low throughout a burst.
- Ordering: requests are strictly serialized, so a read accepted after a write commit always returns the written data.
- RAM is not cleared by reset; contents are X until written.

## Timing
- Reset values: `rd_rdy`, `wr_rdy`, `ret_valid`, `ret_last` = 0 and `ret_data` = 0 while `reset` is high; state = IDLE.
- First cycle after reset deasserts: IDLE, ready outputs high.
- Read accepted at edge T: first `ret_valid` in the cycle following edge T+`RD_LAT`.
  - Line read: beats in 4 consecutive cycles.
  - Next accept possible 1 cycle after the `ret_last` cycle.
- Write accepted at edge T: RAM written at edge T+`WR_LAT`+1; `wr_rdy` high again the cycle after.
- `ret_data` is 0 whenever `ret_valid` = 0.
- `reset` asserted mid-burst or mid-WR_WAIT:
  - Next cycle is IDLE with `ret_valid` = 0.
  - A pending write is dropped (not committed).
- Combinational path `wr_req` -> `rd_rdy`, documented for timing closure.

## Structure
- Package `cache_if_pkg`:
  - Type constants `TYPE_WORD` = 3'b010, `TYPE_LINE` = 3'b100.
  - State enum encoding.
  - Latency field width (4 bits).
- Sub-module `cache_mem_bank`: single-port 2^(`MEM_AW`-2) x 32 RAM with byte write enable. Instantiated 4x, one per word-in-line, allowing a single-cycle line commit and one read per beat.

## Test plan
- After reset: `rd_rdy` = `wr_rdy` = 1. Line write 0x0000_1230 with data {0x44,0x33,0x22,0x11}, then line read 0x0000_1238 -> beats 0x11,0x22,0x33,0x44 starting `RD_LAT`+1 cycles after accept; `ret_last` only on 0x44; `rd_rdy` = 0 throughout.
- Word write 0x0000_1234, `wr_wstrb` = 4'b0010, data 0xAABBCCDD over word 0x22 -> word read 0x0000_1234 returns 0x0000CC22 in 1 beat with `ret_last` = 1.
- `rd_req` and `wr_req` high in the same IDLE cycle -> write accepted and `rd_rdy` = 0 that cycle; read accepted after commit and returns the new data.
- `reset` pulsed on beat 2 of a line read -> `ret_valid` low next cycle, IDLE; a fresh read completes normally.
- Sweep `RD_LAT` 1/2/7 and `WR_LAT` 1/4: measured accept-to-first-beat and accept-to-`wr_rdy` latencies match the Timing formulas exactly.
